ht_stream_adapter: RTL and testbench

- Host-side front/back end for the `ht` parallel sorter.
- Collects `index` elements from a serial valid/ready input stream and packs them into the sorter's parallel input.
- Holds `ht_start` until the sorter signals `over`, then streams the sorted result out serially with valid/ready and a last flag.
- Makes the sorter usable from a streaming fabric and re-arms for the next job automatically.

---
 rtl/ht_stream_adapter.sv | 163 ++++++++++++++++
 tb/tb_ht_stream_adapter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_stream_adapter.sv
// Streaming front/back end for the ht parallel sorter: packs a job of serial
// elements, runs the sorter under a watchdog, then streams the sorted result out.
module ht_stream_adapter #(
    parameter int index   = 8,
    parameter int width   = 5,
    parameter int timeout = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [width-1:0]         s_data,
    output logic                     ht_start,
    output logic [index*width-1:0]   ht_indata,
    input  logic [index*width-1:0]   ht_outdata,
    input  logic                     ht_over,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [width-1:0]         m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     err
);

    localparam int CW = $clog2(index);
    localparam int WW = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(index - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WW-1:0] WD_LAST  = WW'(timeout - 1);
    localparam logic [WW-1:0] WD_ZERO  = WW'(0);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;
    logic [WW-1:0]          wd_r, wd_nxt_s;
    logic                   start_r, start_nxt_s;
    logic                   err_r, err_nxt_s;
    logic                   over_q_r;
    logic [index*width-1:0] indata_r;
    logic [index*width-1:0] outbuf_r;
    logic [width-1:0]       elem_s;
    logic                   in_fire_s, out_fire_s, over_rise_s, capture_s;

    // Only a fresh rising edge of ht_over counts, so a level left over from a previous job is ignored.
    assign over_rise_s = ht_over & ~over_q_r;
    assign in_fire_s   = s_valid & (state_r == LOAD);
    assign out_fire_s  = m_ready & (state_r == DRAIN);

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        wd_nxt_s    = wd_r;
        start_nxt_s = start_r;
        err_nxt_s   = err_r;
        capture_s   = 1'b0;
        case (state_r)
            LOAD: begin
                if (in_fire_s) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = START;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            START: begin
                start_nxt_s = 1'b1;
                wd_nxt_s    = WD_ZERO;
                state_nxt_s = WAIT;
            end
            WAIT: begin
                wd_nxt_s = wd_r + WD_ONE;
                if (over_rise_s) begin
                    capture_s   = 1'b1;
                    start_nxt_s = 1'b0;
                    state_nxt_s = DRAIN;
                end else if (wd_r == WD_LAST) begin
                    err_nxt_s   = 1'b1;
                    start_nxt_s = 1'b0;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DRAIN: begin
                if (out_fire_s) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = LOAD;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = LOAD;
                cnt_nxt_s   = CNT_ZERO;
                start_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters and data buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= LOAD;
            cnt_r    <= CNT_ZERO;
            wd_r     <= WD_ZERO;
            start_r  <= 1'b0;
            err_r    <= 1'b0;
            over_q_r <= 1'b0;
            indata_r <= {(index*width){1'b0}};
            outbuf_r <= {(index*width){1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            wd_r     <= wd_nxt_s;
            start_r  <= start_nxt_s;
            err_r    <= err_nxt_s;
            over_q_r <= ht_over;
            if (capture_s) begin
                outbuf_r <= ht_outdata;
            end
            for (int i = 0; i < index; i++) begin
                if (in_fire_s && (cnt_r == CW'(i))) begin
                    indata_r[i*width +: width] <= s_data;
                end
            end
        end
    end

    // Select the output element addressed by the drain counter.
    always_comb begin
        elem_s = {width{1'b0}};
        for (int i = 0; i < index; i++) begin
            elem_s = (cnt_r == CW'(i)) ? outbuf_r[i*width +: width] : elem_s;
        end
    end

    assign s_ready   = (state_r == LOAD);
    assign busy      = (state_r != LOAD);
    assign m_valid   = (state_r == DRAIN);
    assign m_data    = m_valid ? elem_s : {width{1'b0}};
    assign m_last    = m_valid & (cnt_r == CNT_LAST);
    assign ht_start  = start_r;
    assign ht_indata = indata_r;
    assign err       = err_r;

endmodule

// File: tb/tb_ht_stream_adapter.sv
// Scoreboard bench for ht_stream_adapter with a behavioural sorter model.
module tb_ht_stream_adapter;
    localparam int N  = 8;
    localparam int W  = 5;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst, s_valid, s_ready, ht_start, ht_over, m_valid, m_ready, m_last, busy, err;
    logic [W-1:0]   s_data, m_data;
    logic [N*W-1:0] ht_indata, ht_outdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [5:0]     exp_q[$];
    logic [N*W-1:0] exp_pack = '0;
    int sorter_mode = 0;   // 0 normal, 1 stale level, 2 never finishes
    int start_cyc = 0, start_len = 0, over_cyc = 0, hs_cyc = 0, first_mv_cyc = 0;
    int out_hs = 0, hs_base = 0;
    logic [W-1:0] stall_exp = '0;

    ht_stream_adapter #(.index(N), .width(W), .timeout(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ht_start(ht_start), .ht_indata(ht_indata), .ht_outdata(ht_outdata), .ht_over(ht_over),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] sort_pack(input logic [N*W-1:0] d);
        int v[N];
        int t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) v[i] = int'(d[i*W +: W]);
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_pack();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, 31));
        return r;
    endfunction

    // Sorter model: sorts ht_indata some cycles after ht_start rises; also checks the packing.
    initial begin
        bit in_job;
        int since;
        in_job = 1'b0; since = 0;
        ht_over = 1'b0; ht_outdata = '0;
        forever begin
            @(negedge clk);
            if (ht_start) begin
                if (!in_job) begin
                    in_job = 1'b1; since = 0; start_cyc = cyc; start_len = 0;
                end else begin
                    since++;
                end
                start_len++;
                check("indata_pack", ht_indata, exp_pack);
            end else begin
                in_job = 1'b0;
            end
            case (sorter_mode)
                0: begin
                    if (!ht_start) ht_over = 1'b0;
                    else if (since == 2) begin
                        ht_outdata = sort_pack(ht_indata); ht_over = 1'b1; over_cyc = cyc;
                    end
                end
                1: begin
                    if (!ht_start) begin
                        ht_over = 1'b1; ht_outdata = ~sort_pack(exp_pack);
                    end else if (since == 2) ht_over = 1'b0;
                    else if (since == 4) begin
                        ht_outdata = sort_pack(ht_indata); ht_over = 1'b1; over_cyc = cyc;
                    end
                end
                default: ht_over = 1'b0;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every output handshake.
    logic       mv_prev = 1'b0;
    logic       held = 1'b0;
    logic [5:0] held_v = '0;
    logic [5:0] mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); held = 1'b0; mv_prev = 1'b0;
            end else begin
                if (m_valid && !mv_prev) first_mv_cyc = cyc;
                if (held) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, held_v});
                if (m_valid && exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got m_valid=1 data=%0d expected m_valid=0", m_data);
                end else if (m_valid && m_ready) begin
                    mon_e = exp_q.pop_front();
                    check("out_elem", {m_last, m_data}, mon_e);
                    out_hs++;
                end
                held = m_valid && !m_ready;
                held_v = {m_last, m_data};
                mv_prev = m_valid;
            end
        end
    end

    task automatic push_expected(input logic [N*W-1:0] d);
        logic [N*W-1:0] srt;
        srt = sort_pack(d);
        exp_pack = d;
        stall_exp = srt[3*W +: W];
        for (int i = 0; i < N; i++) exp_q.push_back({1'(i == N - 1), srt[i*W +: W]});
    endtask

    task automatic send_job(input logic [N*W-1:0] d, input int in_mode);
        int idx, guard;
        bit tog;
        idx = 0; guard = 0; tog = 1'b1;
        while (idx < N && guard < 400) begin
            @(posedge clk); #1;
            case (in_mode)
                1: begin s_valid = tog; tog = ~tog; end
                2: s_valid = 1'($urandom_range(0, 1));
                default: s_valid = 1'b1;
            endcase
            s_data = d[idx*W +: W];
            @(negedge clk);
            if (s_valid && s_ready) begin idx++; hs_cyc = cyc; end
            guard++;
        end
        check("in_handshakes", idx, N);
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = '0;
    endtask

    task automatic drain(input int out_mode);
        int guard, stall;
        guard = 0; stall = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(posedge clk); #1;
            if (out_mode == 1) m_ready = 1'($urandom_range(0, 1));
            else if (out_mode == 2 && out_hs == hs_base + 3 && stall < 5) begin
                m_ready = 1'b0; stall++;
                check("stall_data", m_data, stall_exp);
                check("stall_valid", m_valid, 1'b1);
            end else m_ready = 1'b1;
            guard++;
        end
        check("drain_done", exp_q.size(), 0);
        m_ready = 1'b1;
    endtask

    task automatic run_job(input logic [N*W-1:0] d, input int in_mode, input int out_mode);
        push_expected(d);
        send_job(d, in_mode);
        hs_base = out_hs;
        drain(out_mode);
        check("start_latency", start_cyc, hs_cyc + 2);
        check("first_valid_latency", first_mv_cyc, over_cyc + 1);
        check("out_handshakes", out_hs - hs_base, N);
        check("busy_after", busy, 1'b0);
        check("s_ready_after", s_ready, 1'b1);
    endtask

    initial begin
        int basic[N] = '{17, 3, 30, 0, 9, 9, 21, 4};
        logic [N*W-1:0] d;
        int guard;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ht_start", ht_start, 1'b0);
        check("rst_ht_indata", ht_indata, '0);
        rst = 1'b0;

        d = '0;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(basic[i]);
        run_job(d, 0, 0);
        run_job(d, 1, 0);
        run_job(d, 0, 2);

        sorter_mode = 1;
        run_job(rand_pack(), 0, 0);
        sorter_mode = 0;

        // Sorter never answers: watchdog aborts with no output.
        sorter_mode = 2;
        d = rand_pack();
        exp_pack = d;
        send_job(d, 0);
        guard = 0;
        while (guard < 60) begin
            @(posedge clk); #1;
            guard++;
            if (s_ready) break;
        end
        check("timeout_return", s_ready, 1'b1);
        check("timeout_start_len", start_len, TO);
        check("timeout_err", err, 1'b1);
        check("timeout_ht_start", ht_start, 1'b0);
        sorter_mode = 0;

        run_job(rand_pack(), 2, 1);
        check("err_sticky", err, 1'b1);
        for (int k = 0; k < 4; k++) run_job(rand_pack(), 2, 1);

        // Reset in the middle of a drain.
        d = rand_pack();
        push_expected(d);
        send_job(d, 0);
        hs_base = out_hs;
        guard = 0;
        while (out_hs < hs_base + 3 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_mid_progress", out_hs - hs_base, 3);
        rst = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_s_ready", s_ready, 1'b1);
        check("midrst_err", err, 1'b0);
        check("midrst_ht_start", ht_start, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ht_indata", ht_indata, '0);
        rst = 1'b0; m_ready = 1'b1;
        run_job(rand_pack(), 0, 0);
        check("err_after_rst_job", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
